// File: rtl/ds_operand_stage_if.sv
// ds_operand_stage_if: bundles the fetch->decode->execute handshake, the
// regfile read port and the producer-stage bypass bus of ds_operand_stage.
// master = surrounding pipeline (drives fetch side, producers, regfile data),
// slave  = the decode operand stage itself.
interface ds_operand_stage_if #(
   parameter int XLEN      = 32,
   parameter int NUM_SRC   = 2,
   parameter int NUM_FWD   = 3,
   parameter int PAYLOAD_W = 64
);
   logic                      fs_to_ds_valid;
   logic                      ds_allowin;
   logic [PAYLOAD_W-1:0]      fs_payload;
   logic [NUM_SRC*5-1:0]      fs_src;
   logic [NUM_SRC-1:0]        fs_src_en;
   logic                      flush;
   logic                      es_allowin;
   logic                      ds_to_es_valid;
   logic [PAYLOAD_W-1:0]      ds_payload;
   logic [NUM_SRC*XLEN-1:0]   ds_src_value;
   logic [NUM_SRC*5-1:0]      rf_raddr;
   logic [NUM_SRC*XLEN-1:0]   rf_rdata;
   logic [NUM_FWD-1:0]        fwd_valid;
   logic [NUM_FWD-1:0]        fwd_we;
   logic [NUM_FWD*5-1:0]      fwd_dest;
   logic [NUM_FWD-1:0]        fwd_rdy;
   logic [NUM_FWD*XLEN-1:0]   fwd_data;
   logic [31:0]               stall_cnt;

   modport master (
      output fs_to_ds_valid, fs_payload, fs_src, fs_src_en, flush, es_allowin,
             rf_rdata, fwd_valid, fwd_we, fwd_dest, fwd_rdy, fwd_data,
      input  ds_allowin, ds_to_es_valid, ds_payload, ds_src_value, rf_raddr,
             stall_cnt
   );

   modport slave (
      input  fs_to_ds_valid, fs_payload, fs_src, fs_src_en, flush, es_allowin,
             rf_rdata, fwd_valid, fwd_we, fwd_dest, fwd_rdy, fwd_data,
      output ds_allowin, ds_to_es_valid, ds_payload, ds_src_value, rf_raddr,
             stall_cnt
   );
endinterface

// File: rtl/ds_operand_stage.sv
// ds_operand_stage: decode-stage pipeline register with an operand bypass
// network and interlock for NUM_SRC sources against NUM_FWD producer stages
// (stage 0 = youngest, highest priority).
// Optional feature macro HAZARD_FORWARD_EN:
//   defined   - results are forwarded from the youngest matching producer;
//               only an unready winning producer stalls; stall_cnt counts
//               interlock cycles.
//   undefined - no bypass (operands come from the regfile); any enabled
//               source matching any producer stalls; stall_cnt is 0.
module ds_operand_stage #(
   parameter int XLEN      = 32,
   parameter int NUM_SRC   = 2,
   parameter int NUM_FWD   = 3,
   parameter int PAYLOAD_W = 64
) (
   input  logic               clk,
   input  logic               reset,
   ds_operand_stage_if.slave  bus
);

   logic                      vld_p0;
   logic [PAYLOAD_W-1:0]      payload_p0;
   logic [NUM_SRC*5-1:0]      src_p0;
   logic [NUM_SRC-1:0]        src_en_p0;

   logic [NUM_SRC-1:0]        hit;
   logic [NUM_SRC-1:0]        interlock;
   logic [NUM_SRC*XLEN-1:0]   src_value;
   logic                      ready_go;
   logic                      allowin;
   logic                      accept;
`ifdef HAZARD_FORWARD_EN
   logic [NUM_SRC-1:0]        hit_rdy;
   logic [NUM_SRC*XLEN-1:0]   hit_data;
   logic [31:0]               stall_cnt_q;
`else
   logic                      unused_fwd;
`endif

   assign accept = bus.fs_to_ds_valid && allowin;

   // ---- stage p0: fetch -> decode register ----
   // Control: valid bit, flush kills the held instruction before any load.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0 <= 1'b0;
      end else if (bus.flush) begin
         vld_p0 <= 1'b0;
      end else if (allowin) begin
         vld_p0 <= bus.fs_to_ds_valid;
      end
   end

   // Data: payload and source fields load only on accept, never reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         payload_p0 <= bus.fs_payload;
         src_p0     <= bus.fs_src;
         src_en_p0  <= bus.fs_src_en;
      end
   end

   // Per source: find the youngest matching producer (loop runs oldest to
   // youngest so the lowest index wins), then pick the operand and decide
   // whether that winner forces an interlock.
   always_comb begin
      hit       = '0;
      interlock = '0;
      src_value = '0;
`ifdef HAZARD_FORWARD_EN
      hit_rdy   = '0;
      hit_data  = '0;
`endif
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (bus.fwd_valid[k] && bus.fwd_we[k] &&
                bus.fwd_dest[k*5 +: 5] == src_p0[i*5 +: 5] &&
                src_p0[i*5 +: 5] != 5'd0) begin
               hit[i] = 1'b1;
`ifdef HAZARD_FORWARD_EN
               hit_rdy[i]               = bus.fwd_rdy[k];
               hit_data[i*XLEN +: XLEN] = bus.fwd_data[k*XLEN +: XLEN];
`endif
            end
         end
         if (src_p0[i*5 +: 5] == 5'd0) begin
            src_value[i*XLEN +: XLEN] = '0;
`ifdef HAZARD_FORWARD_EN
         end else if (hit[i]) begin
            src_value[i*XLEN +: XLEN] = hit_data[i*XLEN +: XLEN];
`endif
         end else begin
            src_value[i*XLEN +: XLEN] = bus.rf_rdata[i*XLEN +: XLEN];
         end
`ifdef HAZARD_FORWARD_EN
         interlock[i] = src_en_p0[i] && hit[i] && !hit_rdy[i];
`else
         interlock[i] = src_en_p0[i] && hit[i];
`endif
      end
   end

   assign ready_go           = ~|interlock;
   assign allowin            = !vld_p0 || (ready_go && bus.es_allowin);
   assign bus.ds_allowin     = allowin;
   assign bus.ds_to_es_valid = vld_p0 && ready_go && !bus.flush;
   assign bus.ds_payload     = payload_p0;
   assign bus.ds_src_value   = src_value;
   assign bus.rf_raddr       = src_p0;

`ifdef HAZARD_FORWARD_EN
   // Interlock cycle counter; flush cycles and backpressure are not counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else if (vld_p0 && !ready_go && !bus.flush) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`else
   assign bus.stall_cnt = 32'd0;
   // Producer readiness and data have no consumer without the bypass.
   assign unused_fwd    = ^{bus.fwd_rdy, bus.fwd_data};
`endif

endmodule
